// File: rtl/pong_display_scan.sv
// Row-scanning LED-matrix driver for the pong playfield: snapshots paddle and
// ball positions once per frame, shifts each 64-column row out, latches, dwells.
module pong_display_scan #(
    parameter int unsigned SHIFT_DIV = 1,
    parameter int unsigned DWELL     = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] leftPaddlePosition,
    input  logic [31:0] rightPaddlePosition,
    input  logic [5:0]  xBallPosition,
    input  logic [4:0]  yBallPosition,
    input  logic        displayEnable,
    output logic        serialData,
    output logic        shiftClk,
    output logic        latch,
    output logic        outputEnable,
    output logic [4:0]  rowSelect,
    output logic        frameStart
);

    localparam int unsigned ROWS    = 32;
    localparam int unsigned COLS    = 64;
    localparam int unsigned ROW_W   = 5;
    localparam int unsigned COL_W   = 6;
    localparam int unsigned CNT_MAX = (SHIFT_DIV > DWELL) ? SHIFT_DIV : DWELL;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_SNAP  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_DWELL = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   bit_q, bit_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic               phase_q, phase_d;
    logic [ROWS-1:0]    left_q, left_d;
    logic [ROWS-1:0]    right_q, right_d;
    logic [COL_W-1:0]   xball_q, xball_d;
    logic [ROW_W-1:0]   yball_q, yball_d;

    logic               serial_q, serial_d;
    logic               sclk_q, sclk_d;
    logic               latch_q, latch_d;
    logic               oe_q, oe_d;
    logic [ROW_W-1:0]   row_sel_q, row_sel_d;
    logic               frame_start_q, frame_start_d;

    logic [COL_W-1:0]   col_c;
    logic               pixel_c;

    // Next-state logic; outputs are derived from the next state so they are
    // registered yet aligned with the state they describe.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        bit_d         = bit_q;
        div_d         = div_q;
        phase_d       = phase_q;
        left_d        = left_q;
        right_d       = right_q;
        xball_d       = xball_q;
        yball_d       = yball_q;
        frame_start_d = 1'b0;

        case (state_q)
            ST_SNAP: begin
                if (displayEnable) begin
                    state_d       = ST_SHIFT;
                    row_d         = '0;
                    bit_d         = '0;
                    div_d         = '0;
                    phase_d       = 1'b0;
                    left_d        = leftPaddlePosition;
                    right_d       = rightPaddlePosition;
                    xball_d       = xBallPosition;
                    yball_d       = yBallPosition;
                    frame_start_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (div_q == CNT_W'(SHIFT_DIV - 1)) begin
                    div_d = '0;
                    if (phase_q) begin
                        phase_d = 1'b0;
                        if (bit_q == COL_W'(COLS - 1)) begin
                            state_d = ST_LATCH;
                        end else begin
                            bit_d = bit_q + COL_W'(1);
                        end
                    end else begin
                        phase_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            ST_LATCH: begin
                state_d = ST_DWELL;
                div_d   = '0;
            end
            ST_DWELL: begin
                if (div_q == CNT_W'(DWELL - 1)) begin
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    if (row_q == ROW_W'(ROWS - 1)) begin
                        row_d   = '0;
                        state_d = ST_SNAP;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = ST_SHIFT;
                    end
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            default: state_d = ST_SNAP;
        endcase

        // Column 63 is emitted first, so bit index 0 maps to column 63.
        col_c   = COL_W'(COLS - 1) - bit_d;
        pixel_c = ((col_c == COL_W'(0))        && left_d[row_d])  ||
                  ((col_c == COL_W'(COLS - 1)) && right_d[row_d]) ||
                  ((col_c == xball_d) && (row_d == yball_d));

        serial_d  = (state_d == ST_SHIFT) && pixel_c;
        sclk_d    = (state_d == ST_SHIFT) && phase_d;
        latch_d   = (state_d == ST_LATCH);
        oe_d      = (state_d == ST_DWELL);
        row_sel_d = latch_d ? row_d : row_sel_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_SNAP;
            row_q         <= '0;
            bit_q         <= '0;
            div_q         <= '0;
            phase_q       <= 1'b0;
            left_q        <= '0;
            right_q       <= '0;
            xball_q       <= '0;
            yball_q       <= '0;
            serial_q      <= 1'b0;
            sclk_q        <= 1'b0;
            latch_q       <= 1'b0;
            oe_q          <= 1'b0;
            row_sel_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            bit_q         <= bit_d;
            div_q         <= div_d;
            phase_q       <= phase_d;
            left_q        <= left_d;
            right_q       <= right_d;
            xball_q       <= xball_d;
            yball_q       <= yball_d;
            serial_q      <= serial_d;
            sclk_q        <= sclk_d;
            latch_q       <= latch_d;
            oe_q          <= oe_d;
            row_sel_q     <= row_sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign serialData   = serial_q;
    assign shiftClk     = sclk_q;
    assign latch        = latch_q;
    assign outputEnable = oe_q;
    assign rowSelect    = row_sel_q;
    assign frameStart   = frame_start_q;

endmodule

// File: tb/tb_pong_display_scan.sv
// Bench for pong_display_scan: a panel-side monitor rebuilds each shifted row
// and is compared against pixel rules evaluated directly from the positions.
module tb_pong_display_scan;

    localparam int FRAME_CYC = 1 + 32 * (128 * 1 + 1 + 256);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] leftPaddlePosition = 32'h0;
    logic [31:0] rightPaddlePosition = 32'h0;
    logic [5:0]  xBallPosition = 6'd0;
    logic [4:0]  yBallPosition = 5'd0;
    logic        displayEnable = 1'b0;
    logic        serialData;
    logic        shiftClk;
    logic        latch;
    logic        outputEnable;
    logic [4:0]  rowSelect;
    logic        frameStart;

    int checks = 0;
    int failures = 0;

    pong_display_scan dut (
        .clk                 (clk),
        .reset               (reset),
        .leftPaddlePosition  (leftPaddlePosition),
        .rightPaddlePosition (rightPaddlePosition),
        .xBallPosition       (xBallPosition),
        .yBallPosition       (yBallPosition),
        .displayEnable       (displayEnable),
        .serialData          (serialData),
        .shiftClk            (shiftClk),
        .latch               (latch),
        .outputEnable        (outputEnable),
        .rowSelect           (rowSelect),
        .frameStart          (frameStart)
    );

    always #5 clk = ~clk;

    // Panel-side monitor state
    int          cyc = 0;
    int          fs_cnt = 0;
    int          fs_last = 0;
    int          done_interval = 0;
    logic        prev_sclk = 1'b0;
    logic        prev_oe = 1'b0;
    logic [63:0] sh = 64'h0;
    int          nbits = 0;
    logic        row_first = 1'b0;
    int          oe_run = 0;
    int          cur_latches = 0;
    int          seq_bad = 0;
    logic [63:0] cur_rows [32];
    int          cur_nbits [32];
    int          cur_oe [32];
    logic        cur_first [32];
    logic [63:0] done_rows [32];
    int          done_nbits [32];
    int          done_oe [32];
    logic        done_first [32];
    int          done_latches = 0;
    int          done_seq_bad = 0;

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_sclk <= shiftClk;
        prev_oe   <= outputEnable;
        if (shiftClk === 1'b1 && prev_sclk === 1'b0) begin
            sh    <= {sh[62:0], serialData};
            if (nbits == 0) row_first <= serialData;
            nbits <= nbits + 1;
        end
        if (latch === 1'b1) begin
            cur_rows[rowSelect]  <= sh;
            cur_nbits[rowSelect] <= nbits;
            cur_first[rowSelect] <= row_first;
            nbits                <= 0;
            if (int'(rowSelect) != cur_latches) seq_bad <= seq_bad + 1;
            cur_latches          <= cur_latches + 1;
        end
        if (outputEnable === 1'b1) begin
            oe_run <= oe_run + 1;
        end else if (prev_oe === 1'b1) begin
            cur_oe[rowSelect] <= oe_run;
            oe_run            <= 0;
        end
        if (frameStart === 1'b1) begin
            fs_cnt        <= fs_cnt + 1;
            done_interval <= cyc - fs_last;
            fs_last       <= cyc;
            done_rows     <= cur_rows;
            done_nbits    <= cur_nbits;
            done_oe       <= cur_oe;
            done_first    <= cur_first;
            done_latches  <= cur_latches;
            done_seq_bad  <= seq_bad;
            cur_latches   <= 0;
            seq_bad       <= 0;
            nbits         <= 0;
        end
    end

    // Reference pixel rules for one row
    function automatic logic [63:0] exp_row(input logic [31:0] l, input logic [31:0] r,
                                            input int x, input int y, input int row);
        logic [63:0] v;
        v = 64'h0;
        for (int c = 0; c < 64; c++) begin
            if ((c == 0 && l[row]) || (c == 63 && r[row]) || (c == x && row == y)) v[c] = 1'b1;
        end
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fs(input int target, output bit ok);
        int t;
        t = 0;
        while (fs_cnt < target && t < 20000) begin
            tick();
            t++;
        end
        ok = (fs_cnt >= target);
    endtask

    task automatic test_reset();
        int t;
        logic [9:0] outs;
        for (int i = 0; i < 3; i++) begin
            tick();
            outs = {serialData, shiftClk, latch, outputEnable, rowSelect, frameStart};
            checks++;
            if (outs !== 10'h0) begin
                failures++;
                $display("FAIL reset_hold_outputs cycle %0d: got %h expected 0", i, outs);
            end
        end
        reset = 1'b1;
        displayEnable = 1'b1;
        tick();
        checks++;
        if (frameStart !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_framestart: got %b expected 1", frameStart);
        end
        // run into the dwell of row 5, then reset mid-row
        t = 0;
        while (!(latch === 1'b1 && rowSelect == 5'd5) && t < 4000) begin
            tick();
            t++;
        end
        checks++;
        if (t >= 4000) begin
            failures++;
            $display("FAIL reach_row5_latch: timeout got row %0d expected 5", rowSelect);
        end
        repeat (10) tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            outs = {serialData, shiftClk, latch, outputEnable, rowSelect, frameStart};
            checks++;
            if (outs !== 10'h0) begin
                failures++;
                $display("FAIL midrow_reset_outputs cycle %0d: got %h expected 0", i, outs);
            end
        end
        reset = 1'b1;
        tick();
        checks++;
        if (frameStart !== 1'b1) begin
            failures++;
            $display("FAIL rerelease_framestart: got %b expected 1", frameStart);
        end
        t = 0;
        while (latch !== 1'b1 && t < 300) begin
            tick();
            t++;
        end
        checks++;
        if (latch !== 1'b1 || rowSelect !== 5'd0) begin
            failures++;
            $display("FAIL first_latch_row: got latch=%b row=%0d expected latch=1 row=0", latch, rowSelect);
        end
    endtask

    // Frame 1 holds left=0xF, ball (10,2); new inputs applied after frame 2 starts
    task automatic test_left_paddle_ball();
        bit ok;
        int base;
        base = fs_cnt;
        wait_fs(base + 1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL left_frame_wait: timeout got fs=%0d expected %0d", fs_cnt, base + 1);
        end
        rightPaddlePosition = 32'h8000_0000;
        leftPaddlePosition  = 32'h0;
        xBallPosition       = 6'd63;
        yBallPosition       = 5'd31;
        for (int r = 0; r < 32; r++) begin
            checks++;
            if (done_rows[r] !== exp_row(32'hF, 32'h0, 10, 2, r)) begin
                failures++;
                $display("FAIL left_row%0d: got %h expected %h", r, done_rows[r], exp_row(32'hF, 32'h0, 10, 2, r));
            end
        end
        checks++;
        if (done_rows[2] !== 64'h0000_0000_0000_0401 || done_rows[0] !== 64'h1 || done_rows[7] !== 64'h0) begin
            failures++;
            $display("FAIL left_key_rows: got r2=%h r0=%h r7=%h expected 401/1/0", done_rows[2], done_rows[0], done_rows[7]);
        end
    endtask

    // Frame 2 must still show the old snapshot; also check free-run timing
    task automatic test_snapshot_tear();
        bit ok;
        int base;
        int bad_bits;
        int bad_oe;
        base = fs_cnt;
        wait_fs(base + 1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL tear_frame_wait: timeout got fs=%0d expected %0d", fs_cnt, base + 1);
        end
        xBallPosition = 6'd40;
        yBallPosition = 5'd5;
        for (int r = 0; r < 32; r++) begin
            checks++;
            if (done_rows[r] !== exp_row(32'hF, 32'h0, 10, 2, r)) begin
                failures++;
                $display("FAIL tear_row%0d: got %h expected %h", r, done_rows[r], exp_row(32'hF, 32'h0, 10, 2, r));
            end
        end
        checks++;
        if (done_interval != FRAME_CYC || done_interval != 12321) begin
            failures++;
            $display("FAIL frame_interval: got %0d expected 12321", done_interval);
        end
        checks++;
        if (done_latches != 32 || done_seq_bad != 0) begin
            failures++;
            $display("FAIL latch_sequence: got latches=%0d seq_errors=%0d expected 32/0", done_latches, done_seq_bad);
        end
        bad_bits = 0;
        bad_oe = 0;
        for (int r = 0; r < 32; r++) begin
            if (done_nbits[r] != 64) bad_bits++;
            if (done_oe[r] != 256) bad_oe++;
        end
        checks++;
        if (bad_bits != 0) begin
            failures++;
            $display("FAIL shiftclk_edges: got %0d rows without 64 edges (row0=%0d) expected 0", bad_bits, done_nbits[0]);
        end
        checks++;
        if (bad_oe != 0) begin
            failures++;
            $display("FAIL oe_dwell: got %0d rows without 256 lit cycles (row0=%0d) expected 0", bad_oe, done_oe[0]);
        end
    endtask

    // Frame 3 holds right paddle row 31 with ball (63,31), old ball position
    task automatic test_right_paddle(output logic [31:0] rl, output logic [31:0] rr,
                                     output int rx, output int ry);
        bit ok;
        int base;
        base = fs_cnt;
        wait_fs(base + 1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL right_frame_wait: timeout got fs=%0d expected %0d", fs_cnt, base + 1);
        end
        rl = $urandom;
        rr = $urandom;
        rx = int'($urandom_range(63, 0));
        ry = int'($urandom_range(31, 0));
        leftPaddlePosition  = rl;
        rightPaddlePosition = rr;
        xBallPosition       = 6'(rx);
        yBallPosition       = 5'(ry);
        for (int r = 0; r < 32; r++) begin
            checks++;
            if (done_rows[r] !== exp_row(32'h0, 32'h8000_0000, 63, 31, r)) begin
                failures++;
                $display("FAIL right_row%0d: got %h expected %h", r, done_rows[r], exp_row(32'h0, 32'h8000_0000, 63, 31, r));
            end
        end
        checks++;
        if (done_rows[31] !== 64'h8000_0000_0000_0000 || done_first[31] !== 1'b1) begin
            failures++;
            $display("FAIL right_row31_first: got %h first=%b expected 8000000000000000 first=1", done_rows[31], done_first[31]);
        end
    endtask

    // Frame 4 shows the ball moved to (40,5)
    task automatic test_ball_update();
        bit ok;
        int base;
        base = fs_cnt;
        wait_fs(base + 1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL ball_frame_wait: timeout got fs=%0d expected %0d", fs_cnt, base + 1);
        end
        displayEnable = 1'b0;
        for (int r = 0; r < 32; r++) begin
            checks++;
            if (done_rows[r] !== exp_row(32'h0, 32'h8000_0000, 40, 5, r)) begin
                failures++;
                $display("FAIL ball_row%0d: got %h expected %h", r, done_rows[r], exp_row(32'h0, 32'h8000_0000, 40, 5, r));
            end
        end
        checks++;
        if (done_rows[5] !== 64'h0000_0100_0000_0000) begin
            failures++;
            $display("FAIL ball_row5: got %h expected 0000010000000000", done_rows[5]);
        end
    endtask

    // Frame 5 (random positions) completes with displayEnable low, then idles
    task automatic test_display_disable(input logic [31:0] rl, input logic [31:0] rr,
                                        input int rx, input int ry);
        int t;
        int base;
        int nonzero;
        base = fs_cnt;
        t = 0;
        while (cur_latches < 32 && t < 13000) begin
            tick();
            t++;
        end
        repeat (300) tick();
        checks++;
        if (cur_latches != 32) begin
            failures++;
            $display("FAIL frame_completes: got %0d latches expected 32", cur_latches);
        end
        for (int r = 0; r < 32; r++) begin
            checks++;
            if (cur_rows[r] !== exp_row(rl, rr, rx, ry, r)) begin
                failures++;
                $display("FAIL random_row%0d: got %h expected %h", r, cur_rows[r], exp_row(rl, rr, rx, ry, r));
            end
        end
        nonzero = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if ({serialData, shiftClk, latch, outputEnable, frameStart} !== 5'b0) nonzero++;
        end
        checks++;
        if (nonzero != 0) begin
            failures++;
            $display("FAIL idle_outputs: got %0d active cycles expected 0", nonzero);
        end
        checks++;
        if (rowSelect !== 5'd31) begin
            failures++;
            $display("FAIL idle_rowselect_hold: got %0d expected 31", rowSelect);
        end
        checks++;
        if (fs_cnt != base) begin
            failures++;
            $display("FAIL idle_no_framestart: got %0d pulses expected 0", fs_cnt - base);
        end
        displayEnable = 1'b1;
        tick();
        checks++;
        if (frameStart !== 1'b1) begin
            failures++;
            $display("FAIL enable_framestart: got %b expected 1", frameStart);
        end
    endtask

    initial begin
        logic [31:0] rl;
        logic [31:0] rr;
        int rx;
        int ry;
        leftPaddlePosition  = 32'h0000_000F;
        rightPaddlePosition = 32'h0;
        xBallPosition       = 6'd10;
        yBallPosition       = 5'd2;
        test_reset();
        test_left_paddle_ball();
        test_snapshot_tear();
        test_right_paddle(rl, rr, rx, ry);
        test_ball_update();
        test_display_disable(rl, rr, rx, ry);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
